// File: rtl/mario_pkg.sv
// Shared constants and types for the Mario sprite read-side controller.
// Sprite RAM holds NUM_FRAMES frames of SPR_W x SPR_H 4-bit palette indices.
package mario_pkg;

    localparam int unsigned SPR_W           = 20;
    localparam int unsigned SPR_H           = 40;
    localparam int unsigned NUM_FRAMES      = 3;
    localparam int unsigned FRAME_WORDS     = SPR_W * SPR_H;
    localparam int unsigned TICKS_PER_FRAME = 6;

    localparam logic [3:0] KEY_IDX = 4'hE;

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        JUMP   = 2'd1,
        HOLD   = 2'd2
    } anim_state_t;

    localparam logic [18:0] FRAME_BASE_0 = 19'd0;
    localparam logic [18:0] FRAME_BASE_1 = 19'(FRAME_WORDS);
    localparam logic [18:0] FRAME_BASE_2 = 19'(2 * FRAME_WORDS);

    function automatic logic [18:0] frame_base_of(input logic [1:0] frame);
        logic [18:0] base;
        case (frame)
            2'd1:    base = FRAME_BASE_1;
            2'd2:    base = FRAME_BASE_2;
            default: base = FRAME_BASE_0;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/sprite_anim_fsm.sv
// Jump animation sequencer: steps the sprite frame once per TICKS_PER_FRAME
// video frames while airborne and holds the last frame until landing.
module sprite_anim_fsm
    import mario_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        jump,
    output logic [1:0]  anim_frame,
    output logic [18:0] frame_base
);

    localparam logic [1:0] S_GROUND = GROUND;
    localparam logic [1:0] S_JUMP   = JUMP;
    localparam logic [1:0] S_HOLD   = HOLD;

    localparam logic [2:0] TICK_LAST  = 3'(TICKS_PER_FRAME - 1);
    localparam logic [1:0] FRAME_LAST = 2'(NUM_FRAMES - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  tick_q, tick_d;
    logic [1:0]  frame_q, frame_d;
    logic [18:0] base_q, base_d;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        frame_d = frame_q;
        // Everything holds between frame_start pulses so the frame never
        // changes while a line is being drawn.
        if (frame_start) begin
            case (state_q)
                S_GROUND: begin
                    frame_d = 2'd0;
                    tick_d  = 3'd0;
                    if (jump) begin
                        state_d = S_JUMP;
                    end
                end
                S_JUMP: begin
                    if (!jump) begin
                        state_d = S_GROUND;
                        frame_d = 2'd0;
                        tick_d  = 3'd0;
                    end else if (tick_q == TICK_LAST) begin
                        tick_d  = 3'd0;
                        frame_d = frame_q + 2'd1;
                        if (frame_d == FRAME_LAST) begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        tick_d = tick_q + 3'd1;
                    end
                end
                S_HOLD: begin
                    if (!jump) begin
                        state_d = S_GROUND;
                        frame_d = 2'd0;
                        tick_d  = 3'd0;
                    end else begin
                        frame_d = FRAME_LAST;
                    end
                end
                default: begin
                    state_d = S_GROUND;
                    frame_d = 2'd0;
                    tick_d  = 3'd0;
                end
            endcase
        end
        base_d = frame_base_of(frame_d);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_GROUND;
            tick_q  <= 3'd0;
            frame_q <= 2'd0;
            base_q  <= 19'd0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
            base_q  <= base_d;
        end
    end

    assign anim_frame = frame_q;
    assign frame_base = base_q;

endmodule

// File: rtl/mario_sprite_ctrl.sv
// Sprite RAM read controller: per-pixel hit test and address generation, with a
// 2-stage pipeline aligning the hit flag to the registered RAM read data.
module mario_sprite_ctrl
    import mario_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic        jump,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  MarioX,
    input  logic [9:0]  MarioY,
    input  logic [3:0]  ram_data,
    output logic [18:0] READ_ADDR,
    output logic        pix_valid,
    output logic [3:0]  pix_idx,
    output logic [1:0]  anim_frame
);

    logic [18:0] frame_base;

    sprite_anim_fsm u_anim (
        .CLK         (CLK),
        .Reset       (Reset),
        .frame_start (frame_start),
        .jump        (jump),
        .anim_frame  (anim_frame),
        .frame_base  (frame_base)
    );

    // 11-bit compare so a sprite near the right/bottom edge clips, never wraps.
    logic [10:0] draw_x, draw_y, spr_x, spr_y;
    logic        hit;

    assign draw_x = {1'b0, DrawX};
    assign draw_y = {1'b0, DrawY};
    assign spr_x  = {1'b0, MarioX};
    assign spr_y  = {1'b0, MarioY};

    assign hit = (draw_x >= spr_x) && (draw_x < spr_x + 11'(SPR_W)) &&
                 (draw_y >= spr_y) && (draw_y < spr_y + 11'(SPR_H));

    logic [9:0]  col_off, row_off;
    logic [18:0] addr_next;

    assign col_off   = DrawX - MarioX;
    assign row_off   = DrawY - MarioY;
    assign addr_next = hit ? frame_base + 19'(row_off) * 19'(SPR_W) + 19'(col_off)
                           : frame_base;

    logic [18:0] read_addr_q;
    logic        hit_d1, hit_d2;
    logic        pix_valid_q;
    logic [3:0]  pix_idx_q;
    logic        opaque;

    assign opaque = hit_d2 && (ram_data != KEY_IDX);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            read_addr_q <= 19'd0;
            hit_d1      <= 1'b0;
            hit_d2      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_idx_q   <= 4'd0;
        end else begin
            read_addr_q <= addr_next;
            hit_d1      <= hit;
            hit_d2      <= hit_d1;
            pix_valid_q <= opaque;
            pix_idx_q   <= opaque ? ram_data : 4'd0;
        end
    end

    assign READ_ADDR = read_addr_q;
    assign pix_valid = pix_valid_q;
    assign pix_idx   = pix_idx_q;

endmodule

// File: tb/tb_mario_sprite_ctrl.sv
// Self-checking bench for mario_sprite_ctrl: directed vectors, hand sequences
// and random stimulus against a pixel/animation reference model.
module tb_mario_sprite_ctrl;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        jump = 1'b0;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic [9:0]  MarioX = 10'd0;
    logic [9:0]  MarioY = 10'd0;
    logic [3:0]  ram_data = 4'd0;
    logic [18:0] READ_ADDR;
    logic        pix_valid;
    logic [3:0]  pix_idx;
    logic [1:0]  anim_frame;

    mario_sprite_ctrl dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .frame_start (frame_start),
        .jump        (jump),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .MarioX      (MarioX),
        .MarioY      (MarioY),
        .ram_data    (ram_data),
        .READ_ADDR   (READ_ADDR),
        .pix_valid   (pix_valid),
        .pix_idx     (pix_idx),
        .anim_frame  (anim_frame)
    );

    always #5 CLK = ~CLK;

    // Sprite RAM with 1-cycle registered read.
    logic [3:0] mem [0:2399];
    always @(posedge CLK) ram_data <= (READ_ADDR < 19'd2400) ? mem[READ_ADDR] : 4'h0;

    int total = 0;
    int bad = 0;

    // Reference model: airborne pulse count drives the frame; a 2-deep queue of
    // (hit, address) predicts the pixel output.
    int m_frame = 0;
    int m_n = 0;
    bit m_air = 0;
    bit p1_hit = 0, p2_hit = 0;
    int p1_addr = 0, p2_addr = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step();
        int x, y, mx, my, a, ei;
        bit h, ev;
        x = int'(DrawX);
        y = int'(DrawY);
        mx = int'(MarioX);
        my = int'(MarioY);
        h = (x >= mx) && (x < mx + 20) && (y >= my) && (y < my + 40);
        a = m_frame * 800 + (h ? (y - my) * 20 + (x - mx) : 0);
        if (Reset) begin
            ev = 0; ei = 0; a = 0;
            p1_hit = 0; p2_hit = 0; p1_addr = 0; p2_addr = 0;
            m_frame = 0; m_n = 0; m_air = 0;
        end else begin
            ev = p2_hit && (mem[p2_addr] != 4'hE);
            ei = ev ? int'(mem[p2_addr]) : 0;
            p2_hit = p1_hit; p2_addr = p1_addr;
            p1_hit = h; p1_addr = a;
            if (frame_start) begin
                if (!jump) begin
                    m_air = 0; m_n = 0; m_frame = 0;
                end else if (!m_air) begin
                    m_air = 1; m_n = 0; m_frame = 0;
                end else begin
                    m_n++;
                    m_frame = (m_n / 6 > 2) ? 2 : m_n / 6;
                end
            end
        end
        @(posedge CLK);
        #1;
        check("read_addr", READ_ADDR, a);
        check("pix_valid", pix_valid, ev);
        check("pix_idx", pix_idx, ei);
        check("anim_frame", anim_frame, m_frame);
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
        end
    endtask

    typedef struct {
        int dx;
        int dy;
        int mx;
        int my;
        int addr;
    } vec_t;

    vec_t vecs[9];
    int   vcnt;

    initial begin
        vecs[0] = '{105, 203, 100, 200, 65};
        vecs[1] = '{639, 100, 630, 100, 9};
        vecs[2] = '{650, 100, 630, 100, 0};
        vecs[3] = '{120, 200, 100, 200, 0};
        vecs[4] = '{99,  200, 100, 200, 0};
        vecs[5] = '{103, 239, 100, 200, 783};
        vecs[6] = '{103, 240, 100, 200, 0};
        vecs[7] = '{103, 199, 100, 200, 0};
        vecs[8] = '{19,  39,  0,   0,   799};

        for (int i = 0; i < 2400; i++) mem[i] = 4'($urandom);
        for (int i = 0; i < 20; i++) mem[60 + i] = 4'(i % 14);
        mem[65] = 4'h3;
        mem[85] = 4'hE;

        // Reset, including frame_start/jump held off while in reset
        Reset = 1'b1;
        step();
        step();
        jump = 1'b1;
        pulse(1);
        check("reset_hold_frame", anim_frame, 0);
        Reset = 1'b0;
        jump = 1'b0;
        step();

        // Directed hit/address vectors in frame 0
        for (int i = 0; i < 9; i++) begin
            DrawX = 10'(vecs[i].dx);
            DrawY = 10'(vecs[i].dy);
            MarioX = 10'(vecs[i].mx);
            MarioY = 10'(vecs[i].my);
            step();
            check("vec_addr", READ_ADDR, vecs[i].addr);
        end

        // Single pixel with 2-cycle latency
        MarioX = 10'd100; MarioY = 10'd200; DrawX = 10'd105; DrawY = 10'd203;
        step();
        check("px_addr", READ_ADDR, 65);
        DrawX = 10'd0;
        step();
        step();
        check("px_valid", pix_valid, 1);
        check("px_idx", pix_idx, 3);

        // Streaming 20 pixels along one row
        DrawY = 10'd203;
        vcnt = 0;
        for (int i = 0; i < 22; i++) begin
            DrawX = (i < 20) ? 10'(100 + i) : 10'd0;
            step();
            if (i < 20) check("stream_addr", READ_ADDR, 60 + i);
            if (i >= 2 && pix_valid) vcnt++;
        end
        check("stream_valid_count", vcnt, 20);

        // Transparent key colour
        DrawX = 10'd105; DrawY = 10'd204;
        step();
        check("key_addr", READ_ADDR, 85);
        DrawX = 10'd0;
        step();
        step();
        check("key_valid", pix_valid, 0);
        check("key_idx", pix_idx, 0);

        // Jump animation
        DrawX = 10'd0; DrawY = 10'd0;
        jump = 1'b1;
        pulse(1);
        check("jump_enter", anim_frame, 0);
        pulse(6);
        check("jump_f1", anim_frame, 1);
        DrawX = 10'd100; DrawY = 10'd200;
        step();
        check("f1_base", READ_ADDR, 800);
        DrawX = 10'd0;
        pulse(6);
        check("jump_f2", anim_frame, 2);
        DrawX = 10'd100; DrawY = 10'd200;
        step();
        check("f2_base", READ_ADDR, 1600);
        DrawX = 10'd0;
        pulse(20);
        check("hold_f2", anim_frame, 2);
        jump = 1'b0;
        pulse(1);
        check("land", anim_frame, 0);

        // Reset mid-line with hits in flight during frame 1
        jump = 1'b1;
        pulse(7);
        check("pre_rst_frame", anim_frame, 1);
        DrawY = 10'd203;
        for (int i = 0; i < 3; i++) begin
            DrawX = 10'(100 + i);
            step();
        end
        Reset = 1'b1;
        DrawX = 10'd103;
        step();
        check("rst_valid", pix_valid, 0);
        check("rst_frame", anim_frame, 0);
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            DrawX = 10'(104 + i);
            step();
            check("post_rst_valid", pix_valid, (i == 2) ? 1 : 0);
        end

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            Reset = ($urandom_range(0, 99) == 0);
            frame_start = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) jump = ~jump;
            if ($urandom_range(0, 31) == 0) begin
                MarioX = 10'($urandom_range(0, 1023));
                MarioY = 10'($urandom_range(0, 1023));
            end
            DrawX = 10'(MarioX + $urandom_range(0, 26) - 3);
            DrawY = 10'(MarioY + $urandom_range(0, 46) - 3);
            step();
        end
        Reset = 1'b0;
        frame_start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
